// File: rtl/drm_64x8192_arb.sv
// Two-requester access controller for the 64x8192 byte-enabled dual-port RAM.
// m0 reads only, m1 reads/writes; reads share the RAM read port round-robin.
module drm_64x8192_arb #(
   parameter int unsigned ADDR_WIDTH = 13,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned BE_WIDTH   = 8,
   parameter int unsigned CLEAR_EN   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req_valid,
   output logic                  m0_req_ready,
   input  logic [ADDR_WIDTH-1:0] m0_req_addr,
   output logic                  m0_rsp_valid,
   output logic [DATA_WIDTH-1:0] m0_rsp_data,
   input  logic                  m1_req_valid,
   output logic                  m1_req_ready,
   input  logic                  m1_req_wr,
   input  logic [ADDR_WIDTH-1:0] m1_req_addr,
   input  logic [DATA_WIDTH-1:0] m1_req_wdata,
   input  logic [BE_WIDTH-1:0]   m1_req_be,
   output logic                  m1_rsp_valid,
   output logic [DATA_WIDTH-1:0] m1_rsp_data,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  busy
);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;
   localparam logic [0:0] ST_RESET = (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_q, clr_d;
   logic                  ptr_q, ptr_d;      // 0 = m0 has priority on a tie
   logic                  rsp0_q, rsp0_d;
   logic                  rsp1_q, rsp1_d;
   logic                  wr_c, cand0_c, cand1_c, gnt0_c, gnt1_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RESET;
         clr_q   <= '0;
         ptr_q   <= 1'b0;
         rsp0_q  <= 1'b0;
         rsp1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         ptr_q   <= ptr_d;
         rsp0_q  <= rsp0_d;
         rsp1_q  <= rsp1_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      clr_d          = clr_q;
      ptr_d          = ptr_q;
      rsp0_d         = 1'b0;
      rsp1_d         = 1'b0;
      wr_c           = 1'b0;
      cand0_c        = 1'b0;
      cand1_c        = 1'b0;
      gnt0_c         = 1'b0;
      gnt1_c         = 1'b0;
      m0_req_ready   = 1'b0;
      m1_req_ready   = 1'b0;
      ram_wr_en      = 1'b0;
      ram_wr_addr    = m1_req_addr;
      ram_wr_data    = m1_req_wdata;
      ram_wr_byte_en = m1_req_be;
      ram_rd_addr    = '0;
      busy           = 1'b0;

      if (rst) begin
         busy = (CLEAR_EN != 0);
      end else begin
         case (state_q)
            ST_CLEAR: begin
               busy           = 1'b1;
               ram_wr_en      = 1'b1;
               ram_wr_addr    = clr_q;
               ram_wr_data    = '0;
               ram_wr_byte_en = '1;
               clr_d          = clr_q + ADDR_WIDTH'(1);
               if (clr_q == '1) state_d = ST_RUN;
            end
            default: begin
               wr_c      = m1_req_valid & m1_req_wr;
               ram_wr_en = wr_c;
               // m0 reading the word m1 is writing waits one cycle for the new data
               cand0_c   = m0_req_valid & ~(wr_c & (m1_req_addr == m0_req_addr));
               cand1_c   = m1_req_valid & ~m1_req_wr;
               if (cand0_c & cand1_c) begin
                  gnt0_c = ~ptr_q;
                  gnt1_c = ptr_q;
                  ptr_d  = ~ptr_q;
               end else begin
                  gnt0_c = cand0_c;
                  gnt1_c = cand1_c;
               end
               m0_req_ready = gnt0_c;
               m1_req_ready = wr_c | gnt1_c;
               if (gnt0_c)      ram_rd_addr = m0_req_addr;
               else if (gnt1_c) ram_rd_addr = m1_req_addr;
               rsp0_d = gnt0_c;
               rsp1_d = gnt1_c;
            end
         endcase
      end
   end

   assign m0_rsp_valid = rsp0_q & ~rst;
   assign m1_rsp_valid = rsp1_q & ~rst;
   assign m0_rsp_data  = ram_rd_data;
   assign m1_rsp_data  = ram_rd_data;

endmodule

// File: tb/tb_drm_64x8192_arb.sv
// Directed bench for drm_64x8192_arb with CLEAR_EN=1 and a behavioural RAM.
module tb_drm_64x8192_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req_valid, m0_req_ready, m0_rsp_valid;
   logic [12:0] m0_req_addr;
   logic [63:0] m0_rsp_data;
   logic        m1_req_valid, m1_req_ready, m1_req_wr, m1_rsp_valid;
   logic [12:0] m1_req_addr;
   logic [63:0] m1_req_wdata, m1_rsp_data;
   logic [7:0]  m1_req_be;
   logic        ram_wr_en;
   logic [12:0] ram_wr_addr, ram_rd_addr;
   logic [63:0] ram_wr_data, ram_rd_data;
   logic [7:0]  ram_wr_byte_en;
   logic        busy;

   int total = 0;
   int passed = 0;

   logic [63:0] mem [0:8191];

   always #5 clk = ~clk;

   drm_64x8192_arb #(.ADDR_WIDTH(13), .DATA_WIDTH(64), .BE_WIDTH(8), .CLEAR_EN(1)) dut (
      .clk(clk), .rst(rst),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
      .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_wr(m1_req_wr),
      .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_be(m1_req_be),
      .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
      .busy(busy)
   );

   // Behavioural RAM: byte-enabled write, 1-cycle read latency, no output register
   always @(posedge clk) begin
      if (ram_wr_en)
         for (int b = 0; b < 8; b++)
            if (ram_wr_byte_en[b]) mem[ram_wr_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
      ram_rd_data <= mem[ram_rd_addr];
   end

   typedef struct {
      logic        m0v;
      logic [12:0] m0a;
      logic        m1v;
      logic        m1wr;
      logic [12:0] m1a;
      logic [63:0] wd;
      logic [7:0]  be;
      logic        e_r0;
      logic        e_r1;
      logic        e_wen;
      logic [12:0] e_rd;
      logic        e_v0;
      logic        e_v1;
      logic [63:0] e_d;
   } vec_t;

   vec_t vecs[$];

   localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
   localparam logic [63:0] DB = 64'h5555_6666_7777_8888;
   localparam logic [63:0] DC = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] DD = 64'hDEAD_BEEF_0000_7777;

   function automatic vec_t mk(logic m0v, logic [12:0] m0a, logic m1v, logic m1wr,
                               logic [12:0] m1a, logic [63:0] wd, logic [7:0] be,
                               logic e_r0, logic e_r1, logic e_wen, logic [12:0] e_rd,
                               logic e_v0, logic e_v1, logic [63:0] e_d);
      vec_t v;
      v.m0v = m0v; v.m0a = m0a; v.m1v = m1v; v.m1wr = m1wr; v.m1a = m1a;
      v.wd = wd; v.be = be; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_wen = e_wen;
      v.e_rd = e_rd; v.e_v0 = e_v0; v.e_v1 = e_v1; v.e_d = e_d;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   task automatic drive(input logic m0v, input logic [12:0] m0a, input logic m1v,
                        input logic m1wr, input logic [12:0] m1a, input logic [63:0] wd,
                        input logic [7:0] be);
      m0_req_valid = m0v; m0_req_addr = m0a;
      m1_req_valid = m1v; m1_req_wr = m1wr; m1_req_addr = m1a;
      m1_req_wdata = wd; m1_req_be = be;
   endtask

   // Advance one cycle: drive 1 time unit after the edge, sample 1 unit later
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Release reset and run through the clear phase, checking every clear write
   task automatic run_clear(input string tag);
      int ncl = 0;
      int bad = 0;
      next_cycle();
      rst = 1'b0;
      drive(1'b1, 13'd0, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0);
      #1;
      for (int i = 0; i < 9000; i++) begin
         if (!busy) break;
         if (!ram_wr_en || ram_wr_addr !== 13'(ncl) || ram_wr_data !== 64'd0 ||
             ram_wr_byte_en !== 8'hFF || m0_req_ready || m1_req_ready) bad++;
         ncl++;
         next_cycle();
         #1;
      end
      chk({tag, "_busy_cycles"}, 64'(ncl), 64'd8192);
      chk({tag, "_clear_writes_bad"}, 64'(bad), 64'd0);
      chk({tag, "_first_ready"}, 64'(m0_req_ready), 64'd1);
      next_cycle();
      drive(1'b0, 13'd0, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0);
      #1;
      chk({tag, "_first_rsp_valid"}, 64'(m0_rsp_valid), 64'd1);
      chk({tag, "_addr0_cleared"}, m0_rsp_data, 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = '1;
      rst = 1'b1;
      drive(1'b1, 13'd3, 1'b1, 1'b1, 13'd4, 64'hABCD, 8'hFF);

      next_cycle();
      next_cycle();
      #1;
      chk("rst_busy", 64'(busy), 64'd1);
      chk("rst_m0_ready", 64'(m0_req_ready), 64'd0);
      chk("rst_m1_ready", 64'(m1_req_ready), 64'd0);
      chk("rst_rsp_valid", {62'd0, m0_rsp_valid, m1_rsp_valid}, 64'd0);
      chk("rst_wr_en", 64'(ram_wr_en), 64'd0);
      chk("rst_rd_addr", 64'(ram_rd_addr), 64'd0);

      run_clear("clr1");

      vecs.push_back(mk(1, 13'd0,    0, 0, 13'd0,     64'd0, 8'h00, 1, 0, 0, 13'd0,    0, 0, 64'd0));
      vecs.push_back(mk(1, 13'd4095, 0, 0, 13'd0,     64'd0, 8'h00, 1, 0, 0, 13'd4095, 1, 0, 64'd0));
      vecs.push_back(mk(0, 13'd0,    1, 0, 13'd8191,  64'd0, 8'h00, 0, 1, 0, 13'd8191, 1, 0, 64'd0));
      vecs.push_back(mk(0, 13'd0,    0, 0, 13'd0,     64'd0, 8'h00, 0, 0, 0, 13'd0,    0, 1, 64'd0));
      vecs.push_back(mk(0, 13'd0,    1, 1, 13'h010,   DA,    8'hFF, 0, 1, 1, 13'd0,    0, 0, 64'd0));
      vecs.push_back(mk(0, 13'd0,    1, 1, 13'h020,   DB,    8'hFF, 0, 1, 1, 13'd0,    0, 0, 64'd0));
      vecs.push_back(mk(1, 13'h100,  1, 1, 13'h100,   DC,    8'hFF, 0, 1, 1, 13'd0,    0, 0, 64'd0));
      vecs.push_back(mk(1, 13'h100,  0, 0, 13'd0,     64'd0, 8'h00, 1, 0, 0, 13'h100,  0, 0, 64'd0));
      vecs.push_back(mk(0, 13'd0,    0, 0, 13'd0,     64'd0, 8'h00, 0, 0, 0, 13'd0,    1, 0, DC));
      vecs.push_back(mk(0, 13'd0,    1, 1, 13'd5,     '1,    8'hFF, 0, 1, 1, 13'd0,    0, 0, 64'd0));
      vecs.push_back(mk(0, 13'd0,    1, 1, 13'd5,     64'd0, 8'h0F, 0, 1, 1, 13'd0,    0, 0, 64'd0));
      vecs.push_back(mk(0, 13'd0,    1, 0, 13'd5,     64'd0, 8'h00, 0, 1, 0, 13'd5,    0, 0, 64'd0));
      vecs.push_back(mk(0, 13'd0,    0, 0, 13'd0,     64'd0, 8'h00, 0, 0, 0, 13'd0,    0, 1, 64'hFFFF_FFFF_0000_0000));
      vecs.push_back(mk(1, 13'd8,    1, 1, 13'd7,     DD,    8'hFF, 1, 1, 1, 13'd8,    0, 0, 64'd0));
      vecs.push_back(mk(0, 13'd0,    0, 0, 13'd0,     64'd0, 8'h00, 0, 0, 0, 13'd0,    1, 0, 64'd0));
      vecs.push_back(mk(1, 13'h010,  1, 0, 13'h020,   64'd0, 8'h00, 1, 0, 0, 13'h010,  0, 0, 64'd0));
      vecs.push_back(mk(1, 13'h010,  1, 0, 13'h020,   64'd0, 8'h00, 0, 1, 0, 13'h020,  1, 0, DA));
      vecs.push_back(mk(1, 13'h010,  1, 0, 13'h020,   64'd0, 8'h00, 1, 0, 0, 13'h010,  0, 1, DB));
      vecs.push_back(mk(1, 13'h010,  1, 0, 13'h020,   64'd0, 8'h00, 0, 1, 0, 13'h020,  1, 0, DA));
      vecs.push_back(mk(0, 13'd0,    0, 0, 13'd0,     64'd0, 8'h00, 0, 0, 0, 13'd0,    0, 1, DB));
      vecs.push_back(mk(1, 13'h010,  0, 0, 13'd0,     64'd0, 8'h00, 1, 0, 0, 13'h010,  0, 0, 64'd0));
      vecs.push_back(mk(1, 13'h010,  1, 0, 13'h020,   64'd0, 8'h00, 1, 0, 0, 13'h010,  1, 0, DA));
      vecs.push_back(mk(0, 13'd0,    0, 0, 13'd0,     64'd0, 8'h00, 0, 0, 0, 13'd0,    1, 0, DA));
      vecs.push_back(mk(0, 13'd0,    1, 0, 13'd7,     64'd0, 8'h00, 0, 1, 0, 13'd7,    0, 0, 64'd0));
      vecs.push_back(mk(0, 13'd0,    0, 0, 13'd0,     64'd0, 8'h00, 0, 0, 0, 13'd0,    0, 1, DD));

      foreach (vecs[i]) begin
         next_cycle();
         drive(vecs[i].m0v, vecs[i].m0a, vecs[i].m1v, vecs[i].m1wr, vecs[i].m1a,
               vecs[i].wd, vecs[i].be);
         #1;
         chk($sformatf("v%0d_m0_ready", i), 64'(m0_req_ready), 64'(vecs[i].e_r0));
         chk($sformatf("v%0d_m1_ready", i), 64'(m1_req_ready), 64'(vecs[i].e_r1));
         chk($sformatf("v%0d_wr_en", i), 64'(ram_wr_en), 64'(vecs[i].e_wen));
         chk($sformatf("v%0d_rd_addr", i), 64'(ram_rd_addr), 64'(vecs[i].e_rd));
         chk($sformatf("v%0d_m0_rsp_valid", i), 64'(m0_rsp_valid), 64'(vecs[i].e_v0));
         chk($sformatf("v%0d_m1_rsp_valid", i), 64'(m1_rsp_valid), 64'(vecs[i].e_v1));
         if (vecs[i].e_v0) chk($sformatf("v%0d_m0_rsp_data", i), m0_rsp_data, vecs[i].e_d);
         if (vecs[i].e_v1) chk($sformatf("v%0d_m1_rsp_data", i), m1_rsp_data, vecs[i].e_d);
      end

      // Reset in the cycle after a read grant drops the response
      next_cycle();
      drive(1'b1, 13'h010, 1'b0, 1'b0, 13'd0, 64'd0, 8'h00);
      #1;
      chk("mid_grant", 64'(m0_req_ready), 64'd1);
      next_cycle();
      rst = 1'b1;
      drive(1'b1, 13'h010, 1'b1, 1'b1, 13'h030, DD, 8'hFF);
      #1;
      chk("mid_rst_m0_rsp_valid", 64'(m0_rsp_valid), 64'd0);
      chk("mid_rst_m1_rsp_valid", 64'(m1_rsp_valid), 64'd0);
      chk("mid_rst_readies", {62'd0, m0_req_ready, m1_req_ready}, 64'd0);
      chk("mid_rst_wr_en", 64'(ram_wr_en), 64'd0);
      chk("mid_rst_rd_addr", 64'(ram_rd_addr), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd1);
      next_cycle();
      #1;
      chk("mid_rst2_rsp_valid", {62'd0, m0_rsp_valid, m1_rsp_valid}, 64'd0);

      run_clear("clr2");

      // Pointer must be back at m0 after reset
      next_cycle();
      drive(1'b1, 13'h010, 1'b1, 1'b0, 13'h020, 64'd0, 8'h00);
      #1;
      chk("ptr_rst_m0_ready", 64'(m0_req_ready), 64'd1);
      chk("ptr_rst_m1_ready", 64'(m1_req_ready), 64'd0);
      next_cycle();
      #1;
      chk("ptr_rst_alt_m1_ready", 64'(m1_req_ready), 64'd1);
      chk("ptr_rst_rsp_data", m0_rsp_data, 64'd0);
      next_cycle();
      drive(1'b0, 13'd0, 1'b0, 1'b0, 13'd0, 64'd0, 8'h00);
      #1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
